// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_PRIMARIES primaries share one secondary.
// Each granted primary keeps the bus for as long as it holds cyc. A watchdog
// returns a one-cycle err to the holder if the secondary never acks a strobe.
//
// Handshake: a beat completes on the cycle where s_stb=1 and s_ack=1. The
// forwarded p_ack[gnt] is a combinational copy of s_ack. A primary may drop
// cyc in the same cycle it sees its final ack.
module wishbone_rr_arbiter #(
   parameter int NUM_PRIMARIES  = 4,
   parameter int DATA_SIZE      = 32,
   parameter int ADDR_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [NUM_PRIMARIES-1:0]             p_cyc,
   input  logic [NUM_PRIMARIES-1:0]             p_stb,
   input  logic [NUM_PRIMARIES-1:0]             p_we,
   input  logic [NUM_PRIMARIES*ADDR_SIZE-1:0]   p_addr,
   input  logic [NUM_PRIMARIES*DATA_SIZE-1:0]   p_dat_w,
   output logic [DATA_SIZE-1:0]                 p_dat_r,
   output logic [NUM_PRIMARIES-1:0]             p_ack,
   output logic [NUM_PRIMARIES-1:0]             p_err,
   output logic                                 s_cyc,
   output logic                                 s_stb,
   output logic                                 s_we,
   output logic [ADDR_SIZE-1:0]                 s_addr,
   output logic [DATA_SIZE-1:0]                 s_dat_w,
   input  logic [DATA_SIZE-1:0]                 s_dat_r,
   input  logic                                 s_ack,
   output logic [$clog2(NUM_PRIMARIES)-1:0]     gnt,
   output logic [1:0]                           state_dbg
);

   localparam int GW  = $clog2(NUM_PRIMARIES);
   // Keep the watchdog counter at least one bit wide when it is disabled.
   localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t         state_q, state_n;
   logic [GW-1:0]  gnt_q, gnt_n;
   logic [GW-1:0]  rr_q, rr_n;
   logic [GW-1:0]  pick;
   logic [GW-1:0]  gnt_inc;
   logic [WDW-1:0] wd_q, wd_n;
   logic           any_req;
   logic           wd_hit;
   logic [GW:0]    scan_idx;

   // Scan requests starting at rr_q, wrapping explicitly so non-power-of-2 counts work.
   always_comb begin
      any_req  = 1'b0;
      pick     = '0;
      scan_idx = '0;
      for (int i = 0; i < NUM_PRIMARIES; i++) begin
         scan_idx = {1'b0, rr_q} + (GW+1)'(i);
         if (scan_idx >= (GW+1)'(NUM_PRIMARIES)) begin
            scan_idx = scan_idx - (GW+1)'(NUM_PRIMARIES);
         end
         if (!any_req && p_cyc[scan_idx[GW-1:0]]) begin
            any_req = 1'b1;
            pick    = scan_idx[GW-1:0];
         end
      end
   end

   assign gnt_inc = (gnt_q == GW'(NUM_PRIMARIES - 1)) ? '0 : gnt_q + GW'(1);
   assign wd_hit  = (TIMEOUT_CYCLES > 0) && (wd_q == WDW'(TIMEOUT_CYCLES));

   // Next-state logic: grant selection, lock release, watchdog counting.
   always_comb begin
      state_n = state_q;
      gnt_n   = gnt_q;
      rr_n    = rr_q;
      wd_n    = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_n   = pick;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (!p_cyc[gnt_q]) begin
               state_n = IDLE;
               rr_n    = gnt_inc;
            end else if ((TIMEOUT_CYCLES > 0) && p_stb[gnt_q] && !s_ack) begin
               // An ack on the threshold cycle keeps us out of this branch, so ack wins.
               if (wd_hit) begin
                  state_n = ERR;
               end else begin
                  wd_n = wd_q + WDW'(1);
               end
            end
         end
         ERR: begin
            state_n = IDLE;
            rr_n    = gnt_inc;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, grant, round-robin pointer and watchdog registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         rr_q    <= rr_n;
         wd_q    <= wd_n;
      end
   end

   // Bus muxing: the secondary only sees the holder while BUSY; err pulses in ERR.
   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_addr  = '0;
      s_dat_w = '0;
      p_dat_r = '0;
      p_ack   = '0;
      p_err   = '0;
      case (state_q)
         BUSY: begin
            s_cyc        = p_cyc[gnt_q];
            s_stb        = p_stb[gnt_q];
            s_we         = p_we[gnt_q];
            s_addr       = p_addr[gnt_q*ADDR_SIZE +: ADDR_SIZE];
            s_dat_w      = p_dat_w[gnt_q*DATA_SIZE +: DATA_SIZE];
            p_dat_r      = s_dat_r;
            p_ack[gnt_q] = s_ack;
         end
         ERR: begin
            p_err[gnt_q] = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign state_dbg = state_q;

endmodule
